// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: FSM state encodings,
// opcode constants, ALU operation codes and datapath mux select codes.
package mips_mc_pkg;

  // 4-bit state encodings; the value is also exported on the debug state port.
  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRExec   = 4'd6,
    StRWb     = 4'd7,
    StBranch  = 4'd8,
    StJump    = 4'd9,
    StIExec   = 4'd10,
    StIWb     = 4'd11,
    StJal     = 4'd12
  } mips_state_e;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // ALU operation codes; ALU_FUNCT defers to the funct field in the ALU controller.
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_FUNCT = 4'd2;
  localparam logic [3:0] ALU_AND   = 4'd3;
  localparam logic [3:0] ALU_OR    = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // ALU B operand select
  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  // Register destination select
  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  // Register write-back source select
  localparam logic [1:0] MEMTOREG_ALUOUT = 2'd0;
  localparam logic [1:0] MEMTOREG_MDR    = 2'd1;
  localparam logic [1:0] MEMTOREG_PC     = 2'd2;

endpackage

// File: rtl/mips_mc_decode.sv
// Opcode dispatch for the multi-cycle control unit (purely combinational).
//   opcode_i     : instruction[31:26]
//   next_state_o : state entered after DECODE (StFetch for unknown opcodes)
//   illegal_o    : opcode is not supported
//   alu_op_o     : ALU operation for I-type arithmetic (ADD otherwise)
module mips_mc_decode
  import mips_mc_pkg::*;
(
  input  logic [5:0]  opcode_i,
  output mips_state_e next_state_o,
  output logic        illegal_o,
  output logic [3:0]  alu_op_o
);

  always_comb begin
    next_state_o = StFetch;
    illegal_o    = 1'b0;
    alu_op_o     = ALU_ADD;
    case (opcode_i)
      OP_RTYPE:       next_state_o = StRExec;
      OP_LW, OP_SW:   next_state_o = StMemAddr;
      OP_BEQ, OP_BNE: next_state_o = StBranch;
      OP_J:           next_state_o = StJump;
      OP_JAL:         next_state_o = StJal;
      OP_ADDI: begin
        next_state_o = StIExec;
        alu_op_o     = ALU_ADD;
      end
      OP_SLTI: begin
        next_state_o = StIExec;
        alu_op_o     = ALU_SLT;
      end
      OP_ANDI: begin
        next_state_o = StIExec;
        alu_op_o     = ALU_AND;
      end
      OP_ORI: begin
        next_state_o = StIExec;
        alu_op_o     = ALU_OR;
      end
      default:        illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit. Moore-style FSM over a shared datapath with a
// ready-handshaked unified memory port, run/stall input, sticky illegal-opcode
// flag and a saturating retired-instruction counter.
//   clock, Reset      : rising-edge clock, synchronous active-high reset
//   run               : permits a new fetch
//   opcode, funct     : IR fields
//   zero              : ALU zero flag
//   mem_ready         : memory completes the current access this cycle
//   mem_read/mem_write/iord/ir_write/pc_en/pc_source/alu_src_a/alu_src_b/
//   alu_op/reg_write/reg_dst/mem_to_reg : datapath controls (combinational)
//   illegal, retired, state : registered status
module mips_mc_ctrl
  import mips_mc_pkg::*;
#(
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned OPC_W   = 6
) (
  input  logic               clock,
  input  logic               Reset,
  input  logic               run,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [OPC_W-1:0]   funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_en,
  output logic [1:0]         pc_source,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired,
  output logic [3:0]         state
);

  mips_state_e        state_q, state_d;
  logic               illegal_q;
  logic [CNT_W-1:0]   retired_q;
  logic               retire;
  logic               branch_ne;
  logic [3:0]         alu_op_c;

  mips_state_e        dec_next;
  logic               dec_illegal;
  logic [3:0]         dec_alu_op;

  // funct is consumed by the downstream ALU controller, not here.
  logic unused_funct;
  assign unused_funct = ^funct;

  mips_mc_decode u_decode (
    .opcode_i     (opcode[5:0]),
    .next_state_o (dec_next),
    .illegal_o    (dec_illegal),
    .alu_op_o     (dec_alu_op)
  );

  assign branch_ne = (opcode[5:0] == OP_BNE);

  // Next state and retire strobe
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      StFetch:   if (run && mem_ready) state_d = StDecode;
      StDecode:  state_d = dec_next;
      StMemAddr: state_d = (opcode[5:0] == OP_LW) ? StMemRd : StMemWr;
      StMemRd:   if (mem_ready) state_d = StMemWb;
      StMemWr: begin
        if (mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StRExec:   state_d = StRWb;
      StIExec:   state_d = StIWb;
      StMemWb, StRWb, StIWb, StBranch, StJump, StJal: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      default:   state_d = StFetch;
    endcase
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode && dec_illegal) illegal_q <= 1'b1;
      if (retire && retired_q != {CNT_W{1'b1}}) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Control outputs, forced low while Reset is asserted
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_source  = PCSRC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op_c   = ALU_ADD;
    reg_write  = 1'b0;
    reg_dst    = REGDST_RT;
    mem_to_reg = MEMTOREG_ALUOUT;
    if (!Reset) begin
      case (state_q)
        StFetch: begin
          if (run) begin
            mem_read = 1'b1;
            if (mem_ready) begin
              ir_write  = 1'b1;
              alu_src_b = SRCB_FOUR;
              pc_en     = 1'b1;
            end
          end
        end
        StDecode:  alu_src_b = SRCB_IMM_SH;
        StMemAddr: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        StMemRd: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        StMemWb: begin
          reg_write  = 1'b1;
          mem_to_reg = MEMTOREG_MDR;
        end
        StMemWr: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        StRExec: begin
          alu_src_a = 1'b1;
          alu_op_c  = ALU_FUNCT;
        end
        StRWb: begin
          reg_write = 1'b1;
          reg_dst   = REGDST_RD;
        end
        StBranch: begin
          alu_src_a = 1'b1;
          alu_op_c  = ALU_SUB;
          pc_source = PCSRC_ALUOUT;
          pc_en     = zero ^ branch_ne;
        end
        StJump: begin
          pc_source = PCSRC_JUMP;
          pc_en     = 1'b1;
        end
        StJal: begin
          pc_source  = PCSRC_JUMP;
          pc_en      = 1'b1;
          reg_write  = 1'b1;
          reg_dst    = REGDST_RA;
          mem_to_reg = MEMTOREG_PC;
        end
        StIExec: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op_c  = dec_alu_op;
        end
        StIWb:     reg_write = 1'b1;
        default: ;
      endcase
    end
  end

  assign alu_op  = ALUOP_W'(alu_op_c);
  assign illegal = illegal_q;
  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: directed scenarios plus randomized
// instruction streams checked against a per-instruction phase model.
module tb_mips_mc_ctrl;

  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             Reset = 1'b1;
  logic             run = 1'b0;
  logic [5:0]       opcode = '0;
  logic [5:0]       funct = '0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_read, mem_write, iord, ir_write, pc_en;
  logic [1:0]       pc_source, alu_src_b, reg_dst, mem_to_reg;
  logic             alu_src_a, reg_write, illegal;
  logic [3:0]       alu_op, state;
  logic [CNT_W-1:0] retired;

  mips_mc_ctrl #(.ALUOP_W(4), .CNT_W(CNT_W), .OPC_W(6)) dut (
    .clock      (clock),
    .Reset      (Reset),
    .run        (run),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_en      (pc_en),
    .pc_source  (pc_source),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .illegal    (illegal),
    .retired    (retired),
    .state      (state)
  );

  always #5 clock = ~clock;

  logic [18:0] act_cw;
  assign act_cw = {mem_read, mem_write, iord, ir_write, pc_en, pc_source, alu_src_a,
                   alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg};

  int n_cmp = 0;
  int n_err = 0;
  int n_cyc;
  int n_irw;
  int m_retired;
  logic m_illegal;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Expected control word, one argument per output field.
  function automatic logic [18:0] cw(input logic mr, input logic mw, input logic io,
                                     input logic irw, input logic pce, input logic [1:0] pcs,
                                     input logic asa, input logic [1:0] asb,
                                     input logic [3:0] aop, input logic rw,
                                     input logic [1:0] rd, input logic [1:0] mtr);
    return {mr, mw, io, irw, pce, pcs, asa, asb, aop, rw, rd, mtr};
  endfunction

  // One clock: drive mem_ready, check state/controls mid-cycle, advance past the edge.
  task automatic cyc(input string tag, input logic [3:0] es, input logic [18:0] ec,
                     input logic mr);
    mem_ready = mr;
    #1;
    check({tag, "_state"}, 32'(state), 32'(es));
    check({tag, "_ctl"}, 32'(act_cw), 32'(ec));
    if (ir_write) n_irw++;
    n_cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    run       = 1'($urandom_range(0, 1));
    mem_ready = 1'b1;
    Reset     = 1'b1;
    #1;
    check("rst_ctl_zero", 32'(act_cw), 32'd0);
    @(posedge clock);
    #1;
    Reset     = 1'b0;
    m_retired = 0;
    m_illegal = 1'b0;
    check("rst_state", 32'(state), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
  endtask

  // Cycles per instruction with memory always ready.
  function automatic int base_latency(input logic [5:0] op);
    case (op)
      6'h23:                      return 5;
      6'h2B, 6'h00:               return 4;
      6'h08, 6'h0A, 6'h0C, 6'h0D: return 4;
      6'h04, 6'h05, 6'h02, 6'h03: return 3;
      default:                    return 2;
    endcase
  endfunction

  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          input int fwait, input int mwait);
    logic [18:0] wait_cw;
    int exp_cyc;
    n_cyc  = 0;
    n_irw  = 0;
    run    = 1'b1;
    opcode = op;
    funct  = fn;
    zero   = z;
    wait_cw = cw(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < fwait; i++) cyc("fetch_wait", 4'd0, wait_cw, 1'b0);
    cyc("fetch", 4'd0, cw(1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0), 1'b1);
    cyc("decode", 4'd1, cw(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0), 1'($urandom_range(0, 1)));
    exp_cyc = base_latency(op) + fwait;
    case (op)
      6'h00: begin
        cyc("r_exec", 4'd6, cw(0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0), 1'($urandom_range(0, 1)));
        cyc("r_wb", 4'd7, cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), 1'($urandom_range(0, 1)));
      end
      6'h23: begin
        cyc("mem_addr", 4'd2, cw(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0), 1'($urandom_range(0, 1)));
        for (int i = 0; i < mwait; i++)
          cyc("mem_rd_wait", 4'd3, cw(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        cyc("mem_rd", 4'd3, cw(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        cyc("mem_wb", 4'd4, cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), 1'($urandom_range(0, 1)));
        exp_cyc += mwait;
      end
      6'h2B: begin
        cyc("mem_addr", 4'd2, cw(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0), 1'($urandom_range(0, 1)));
        for (int i = 0; i < mwait; i++)
          cyc("mem_wr_wait", 4'd5, cw(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        cyc("mem_wr", 4'd5, cw(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        exp_cyc += mwait;
      end
      6'h04, 6'h05:
        cyc("branch", 4'd8, cw(0, 0, 0, 0, z ^ (op == 6'h05), 1, 1, 0, 1, 0, 0, 0),
            1'($urandom_range(0, 1)));
      6'h02:
        cyc("jump", 4'd9, cw(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0), 1'($urandom_range(0, 1)));
      6'h03:
        cyc("jal", 4'd12, cw(0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 2, 2), 1'($urandom_range(0, 1)));
      6'h08, 6'h0A, 6'h0C, 6'h0D: begin
        logic [3:0] aop;
        aop = (op == 6'h08) ? 4'd0 : (op == 6'h0A) ? 4'd5 : (op == 6'h0C) ? 4'd3 : 4'd4;
        cyc("i_exec", 4'd10, cw(0, 0, 0, 0, 0, 0, 1, 2, aop, 0, 0, 0), 1'($urandom_range(0, 1)));
        cyc("i_wb", 4'd11, cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1'($urandom_range(0, 1)));
      end
      default: m_illegal = 1'b1;
    endcase
    if (base_latency(op) > 2 && m_retired < SAT) m_retired++;
    check("cycles", 32'(n_cyc), 32'(exp_cyc));
    check("ir_write_once", 32'(n_irw), 32'd1);
    check("retired", 32'(retired), 32'(m_retired));
    check("illegal", 32'(illegal), 32'(m_illegal));
    check("back_in_fetch", 32'(state), 32'd0);
  endtask

  logic [5:0] legal_ops [11] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03,
                                 6'h08, 6'h0A, 6'h0C, 6'h0D};
  logic [5:0] bad_ops [4] = '{6'h3F, 6'h01, 6'h10, 6'h2A};

  initial begin
    m_retired = 0;
    m_illegal = 1'b0;
    @(posedge clock);
    #1;
    do_reset();

    // Directed scenarios
    do_instr(6'h00, 6'h20, 1'b0, 0, 0);
    do_instr(6'h23, 6'h00, 1'b0, 2, 3);
    do_instr(6'h04, 6'h00, 1'b1, 0, 0);
    do_instr(6'h05, 6'h00, 1'b1, 0, 0);
    do_instr(6'h05, 6'h00, 1'b0, 0, 0);
    do_instr(6'h03, 6'h00, 1'b0, 0, 0);
    do_instr(6'h2B, 6'h00, 1'b0, 1, 2);
    do_instr(6'h3F, 6'h00, 1'b0, 0, 0);

    // Reset arriving while a lw waits in MEM_RD
    n_cyc  = 0;
    n_irw  = 0;
    opcode = 6'h23;
    run    = 1'b1;
    cyc("rl_fetch", 4'd0, cw(1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0), 1'b1);
    cyc("rl_decode", 4'd1, cw(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0), 1'b1);
    cyc("rl_mem_addr", 4'd2, cw(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0), 1'b1);
    cyc("rl_mem_rd", 4'd3, cw(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    do_reset();
    run = 1'b0;
    cyc("rl_after", 4'd0, 19'd0, 1'b1);

    // Counter saturation
    for (int i = 0; i < 17; i++) do_instr(6'h00, 6'h20, 1'b0, 0, 0);
    check("sat_retired", 32'(retired), 32'(SAT));

    // Stall: run low holds FETCH with nothing asserted
    run = 1'b0;
    for (int i = 0; i < 3; i++) cyc("stall", 4'd0, 19'd0, 1'($urandom_range(0, 1)));

    // Randomized stream
    for (int k = 0; k < 150; k++) begin
      logic [5:0] op;
      if ($urandom_range(0, 19) == 0) do_reset();
      if ($urandom_range(0, 3) == 0) begin
        run = 1'b0;
        for (int i = 0; i < int'($urandom_range(1, 2)); i++)
          cyc("rnd_stall", 4'd0, 19'd0, 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 9) == 0) op = bad_ops[$urandom_range(0, 3)];
      else op = legal_ops[$urandom_range(0, 10)];
      do_instr(op, 6'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multi-cycle control unit, the successor to the single-cycle `control` + `ula_ctrl` pair.
- A Moore-style FSM sequences fetch/decode/execute/memory/writeback over a shared datapath.
- Supports variable-latency memory through a ready handshake, a run/stall input, illegal-opcode detection and a retired-instruction counter.
- Sits between `int_mem`/`dmem` (unified memory port) and the datapath muxes, PC and IR registers.

Parameters:
- ALUOP_W, 4, width of alu_op output (codes defined in package).
- CNT_W, 32, width of retired-instruction counter (saturating).
- OPC_W, 6, opcode/funct field width.

Ports:
- clock  in  1  single system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- run  in  1  1 = allowed to start a new fetch.
- opcode  in  OPC_W  instruction[31:26] from IR.
- funct  in  OPC_W  instruction[5:0] from IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current read/write this cycle.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory.
- ir_write  out  1  load IR.
- pc_en  out  1  PC load enable: pc_write | (branch state & (zero ^ branch_ne)).
- pc_source  out  2  0 = ALU result, 1 = ALUOut (branch target), 2 = jump target.
- alu_src_a  out  1  0 = PC, 1 = rs.
- alu_src_b  out  2  0 = rt, 1 = constant 4, 2 = sign-extended imm, 3 = sign-extended imm << 2.
- alu_op  out  ALUOP_W  ADD = 0, SUB = 1, FUNCT = 2, AND = 3, OR = 4, SLT = 5.
- reg_write  out  1  register file write enable.
- reg_dst  out  2  0 = rt, 1 = rd, 2 = $31.
- mem_to_reg  out  2  0 = ALUOut, 1 = MDR, 2 = PC (link).
- illegal  out  1  sticky; set on unknown opcode.
- retired  out  CNT_W  count of completed instructions.
- state  out  4  current state, for debug.

Behaviour:
- Reset:
  - On a rising clock edge with Reset = 1: state <= FETCH, retired <= 0, illegal <= 0.
  - All control outputs are forced to 0 combinationally while Reset = 1.
  - Reset mid-instruction abandons that instruction with no writes; takes priority over all other events.
- Outputs are decoded from state, plus mem_ready where noted. No output is registered except illegal, retired and state.
- FETCH (0):
  - run = 0: hold, all outputs 0.
  - run = 1: mem_read = 1, iord = 0.
  - When mem_ready = 1 in the same cycle: ir_write = 1, alu_src_a = 0, alu_src_b = 1, alu_op = ADD, pc_source = 0, pc_en = 1, then go to DECODE.
  - Otherwise hold, with no IR or PC write.
- DECODE (1):
  - alu_src_a = 0, alu_src_b = 3, alu_op = ADD (branch target into ALUOut).
  - Dispatch on opcode:
    - 0x00 -> R_EXEC
    - 0x23 or 0x2B -> MEM_ADDR
    - 0x04 or 0x05 -> BRANCH
    - 0x02 -> JUMP
    - 0x03 -> JAL
    - 0x08, 0x0A, 0x0C, 0x0D -> I_EXEC
    - anything else -> FETCH, with illegal <= 1 and retired unchanged.
- MEM_ADDR (2): alu_src_a = 1, alu_src_b = 2, ADD. Go to MEM_RD for lw, MEM_WR for sw.
- MEM_RD (3): mem_read = 1, iord = 1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB (4): reg_write = 1, reg_dst = 0, mem_to_reg = 1. Retire, go to FETCH.
- MEM_WR (5): mem_write = 1, iord = 1. Hold until mem_ready, then retire and go to FETCH.
- R_EXEC (6): alu_src_a = 1, alu_src_b = 0, alu_op = FUNCT. Go to R_WB.
- R_WB (7): reg_write = 1, reg_dst = 1, mem_to_reg = 0. Retire, go to FETCH.
- BRANCH (8):
  - alu_src_a = 1, alu_src_b = 0, SUB, pc_source = 1.
  - Internal branch_ne = (opcode == 0x05).
  - pc_en = zero ^ branch_ne. Retire, go to FETCH.
- JUMP (9): pc_source = 2, pc_en = 1. Retire, go to FETCH.
- JAL (12): pc_source = 2, pc_en = 1, reg_write = 1, reg_dst = 2, mem_to_reg = 2. Retire, go to FETCH.
- I_EXEC (10):
  - alu_src_a = 1, alu_src_b = 2.
  - alu_op: ADD for 0x08, SLT for 0x0A, AND for 0x0C, OR for 0x0D.
  - Go to I_WB.
- I_WB (11): reg_write = 1, reg_dst = 0, mem_to_reg = 0. Retire, go to FETCH.
- Unused state encodings go to FETCH next cycle with all outputs 0.
- Latency with mem_ready held 1 (cycles per instruction): lw 5, sw 4, R 4, I 4, beq/bne 3, j/jal 3.
- Each memory wait cycle adds 1 cycle.
- retired:
  - +1 on the final cycle of each legal instruction.
  - Saturates at 2^CNT_W - 1; no wrap.
- mem_read and mem_write are never both 1.
- ir_write = 1 only in FETCH with mem_ready = 1.

Decomposition:
- Package mips_mc_pkg holds:
  - the state enum (4-bit encodings above);
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI;
  - the ALU_* op codes;
  - the pc_source, reg_dst and mem_to_reg select codes.
- One combinational sub-module, mips_mc_decode: opcode -> next dispatch state plus I-type alu_op.
- FSM, output decode and counter live in mips_mc_ctrl.

Test Plan:
- Reset, then run = 1, mem_ready = 1, opcode = 0x00, funct = 0x20.
  - Expect states 0, 1, 6, 7, 0.
  - R_WB shows reg_write = 1, reg_dst = 1.
  - retired = 1 after 4 cycles.
- lw (0x23) with mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_RD.
  - Expect total 10 cycles.
  - ir_write pulses exactly once.
  - MEM_WB has mem_to_reg = 1.
- beq (0x04) with zero = 1: pc_en = 1, pc_source = 1 in BRANCH.
  - bne (0x05) with zero = 1: pc_en = 0.
  - bne with zero = 0: pc_en = 1.
- jal (0x03): 3 cycles; JAL state shows reg_dst = 2, mem_to_reg = 2, reg_write = 1, pc_source = 2.
- opcode 0x3F: illegal = 1 after DECODE, FSM back in FETCH, retired unchanged.
  - Then assert Reset during MEM_RD of a following lw: next state is FETCH, illegal = 0, retired = 0, no reg_write.
- Preload the counter near saturation (CNT_W = 4, run 17 R-type instructions): retired stops at 15.
  - run = 0 holds FETCH with mem_read = 0.
